// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves RV32I conditional branches, JAL and JALR in a
// two-stage valid/ready pipeline (E1 compute, E2 output register). It checks
// the predicted direction and target, and produces the link value and the
// redirect PC. Supports backpressure and a synchronous flush.
// Optional feature macro: BRU_STATS_EN adds saturating handshake counters.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int ROB_TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [3:0]           op_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [XLEN-1:0]      imm_i,
  input  logic [XLEN-1:0]      rs1_val_i,
  input  logic [XLEN-1:0]      rs2_val_i,
  input  logic                 pred_taken_i,
  input  logic [XLEN-1:0]      pred_target_i,
  input  logic [ROB_TAG_W-1:0] rob_tag_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ROB_TAG_W-1:0] rob_tag_o,
  output logic                 taken_o,
  output logic [XLEN-1:0]      target_o,
  output logic [XLEN-1:0]      link_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  output logic                 mispredict_o
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]          stat_branches_o,
  output logic [31:0]          stat_mispred_o
`endif
);

  typedef enum logic [3:0] {
    OP_BEQ  = 4'd0,
    OP_BNE  = 4'd1,
    OP_BLT  = 4'd4,
    OP_BGE  = 4'd5,
    OP_BLTU = 4'd6,
    OP_BGEU = 4'd7,
    OP_JAL  = 4'd8,
    OP_JALR = 4'd9
  } op_e;

  // E1 stage registers
  logic                 r_e1_valid;
  logic [3:0]           r_e1_op;
  logic [XLEN-1:0]      r_e1_pc;
  logic [XLEN-1:0]      r_e1_imm;
  logic [XLEN-1:0]      r_e1_rs1;
  logic [XLEN-1:0]      r_e1_rs2;
  logic                 r_e1_pred_taken;
  logic [XLEN-1:0]      r_e1_pred_target;
  logic [ROB_TAG_W-1:0] r_e1_tag;

  // E2 (output) stage registers
  logic                 r_e2_valid;
  logic [ROB_TAG_W-1:0] r_e2_tag;
  logic                 r_e2_taken;
  logic [XLEN-1:0]      r_e2_target;
  logic [XLEN-1:0]      r_e2_link;
  logic [XLEN-1:0]      r_e2_redirect;
  logic                 r_e2_mispredict;

  // E1 combinational results
  logic                 w_e2_free;
  logic                 w_e1_free;
  logic                 w_taken;
  logic [XLEN-1:0]      w_jalr_sum;
  logic [XLEN-1:0]      w_target;
  logic [XLEN-1:0]      w_link;
  logic                 w_mispredict;

  // Advance conditions: a stage may load when it is empty or its contents leave
  assign w_e2_free  = !r_e2_valid || out_ready_i;
  assign w_e1_free  = !r_e1_valid || w_e2_free;
  assign in_ready_o = w_e1_free;

  // Resolve direction, targets and misprediction from the E1 registers
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_taken    = 1'b0;
    w_jalr_sum = r_e1_rs1 + r_e1_imm;
    w_target   = r_e1_pc + r_e1_imm;
    w_link     = r_e1_pc + XLEN'(4);
    case (r_e1_op)
      OP_BEQ:  w_taken = (r_e1_rs1 == r_e1_rs2);
      OP_BNE:  w_taken = (r_e1_rs1 != r_e1_rs2);
      OP_BLT:  w_taken = ($signed(r_e1_rs1) <  $signed(r_e1_rs2));
      OP_BGE:  w_taken = ($signed(r_e1_rs1) >= $signed(r_e1_rs2));
      OP_BLTU: w_taken = (r_e1_rs1 <  r_e1_rs2);
      OP_BGEU: w_taken = (r_e1_rs1 >= r_e1_rs2);
      OP_JAL:  w_taken = 1'b1;
      OP_JALR: begin
        w_taken  = 1'b1;
        w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
      end
      default: w_taken = 1'b0;  // reserved ops resolve not-taken
    endcase
    w_mispredict = (w_taken != r_e1_pred_taken) ||
                   (w_taken && r_e1_pred_taken && (w_target != r_e1_pred_target));
  end

  // E1 register: capture an accepted op; flush drops both held and offered ops
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: payload registers are reset too, because the outputs must read zero after reset.
    if (!rst) begin
      r_e1_valid       <= 1'b0;
      r_e1_op          <= '0;
      r_e1_pc          <= '0;
      r_e1_imm         <= '0;
      r_e1_rs1         <= '0;
      r_e1_rs2         <= '0;
      r_e1_pred_taken  <= 1'b0;
      r_e1_pred_target <= '0;
      r_e1_tag         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (flush_i)        r_e1_valid <= 1'b0;
      else if (w_e1_free) r_e1_valid <= in_valid_i;
      if (!flush_i && w_e1_free && in_valid_i) begin
        r_e1_op          <= op_i;
        r_e1_pc          <= pc_i;
        r_e1_imm         <= imm_i;
        r_e1_rs1         <= rs1_val_i;
        r_e1_rs2         <= rs2_val_i;
        r_e1_pred_taken  <= pred_taken_i;
        r_e1_pred_target <= pred_target_i;
        r_e1_tag         <= rob_tag_i;
      end
    end
  end

  // E2 register: take the E1 result when free, hold it stable under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e2_valid      <= 1'b0;
      r_e2_tag        <= '0;
      r_e2_taken      <= 1'b0;
      r_e2_target     <= '0;
      r_e2_link       <= '0;
      r_e2_redirect   <= '0;
      r_e2_mispredict <= 1'b0;
    end else begin
      if (flush_i)        r_e2_valid <= 1'b0;
      else if (w_e2_free) r_e2_valid <= r_e1_valid;
      if (!flush_i && w_e2_free && r_e1_valid) begin
        r_e2_tag        <= r_e1_tag;
        r_e2_taken      <= w_taken;
        r_e2_target     <= w_target;
        r_e2_link       <= w_link;
        r_e2_redirect   <= w_taken ? w_target : w_link;
        r_e2_mispredict <= w_mispredict;
      end
    end
  end

  assign out_valid_o   = r_e2_valid;
  assign rob_tag_o     = r_e2_tag;
  assign taken_o       = r_e2_taken;
  assign target_o      = r_e2_target;
  assign link_o        = r_e2_link;
  assign redirect_pc_o = r_e2_redirect;
  assign mispredict_o  = r_e2_mispredict;

`ifdef BRU_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispred;

  // Saturating counters of delivered results; flush does not clear them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else if (r_e2_valid && out_ready_i) begin
      if (r_stat_branches != 32'hFFFF_FFFF) r_stat_branches <= r_stat_branches + 32'd1;
      if (r_e2_mispredict && (r_stat_mispred != 32'hFFFF_FFFF))
        r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_branches_o = r_stat_branches;
  assign stat_mispred_o  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table,
// backpressure / flush / async-reset sequences, then randomized traffic
// against a queue-based reference model.
module tb_branch_resolve_unit;
  localparam int XLEN = 32;
  localparam int TW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [3:0]      op_i;
  logic [XLEN-1:0] pc_i, imm_i, rs1_val_i, rs2_val_i, pred_target_i;
  logic            pred_taken_i;
  logic [TW-1:0]   rob_tag_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [TW-1:0]   rob_tag_o;
  logic            taken_o;
  logic [XLEN-1:0] target_o, link_o, redirect_pc_o;
  logic            mispredict_o;
`ifdef BRU_STATS_EN
  logic [31:0]     stat_branches_o, stat_mispred_o;
`endif

  branch_resolve_unit #(.XLEN(XLEN), .ROB_TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .pc_i(pc_i), .imm_i(imm_i),
    .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .rob_tag_i(rob_tag_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .rob_tag_o(rob_tag_o), .taken_o(taken_o), .target_o(target_o),
    .link_o(link_o), .redirect_pc_o(redirect_pc_o), .mispredict_o(mispredict_o)
`ifdef BRU_STATS_EN
    , .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] redirect;
    logic            mis;
  } res_t;

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] pc, imm, rs1, rs2;
    logic            pt;
    logic [XLEN-1:0] ptgt;
    res_t            exp;
  } vec_t;

  typedef struct {
    logic [TW-1:0] tag;
    res_t          res;
    int            stamp;
  } entry_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: RV32I branch semantics computed with plain integer arithmetic
  function automatic res_t ref_result(input logic [3:0] op, input logic [XLEN-1:0] pc,
                                      input logic [XLEN-1:0] imm, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b, input logic pt,
                                      input logic [XLEN-1:0] ptgt);
    res_t r;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    longint t;
    r.link = XLEN'(longint'(pc) + 4);
    if (op == 4'd9) begin
      t = (ua + longint'({32'd0, imm})) % (64'sd1 << XLEN);
      r.target = XLEN'(t - (t % 2));
    end else begin
      r.target = XLEN'(longint'({32'd0, pc}) + longint'({32'd0, imm}));
    end
    case (op)
      4'd0:       r.taken = (ua == ub);
      4'd1:       r.taken = (ua != ub);
      4'd4:       r.taken = (sa < sb);
      4'd5:       r.taken = !(sa < sb);
      4'd6:       r.taken = (ua < ub);
      4'd7:       r.taken = !(ua < ub);
      4'd8, 4'd9: r.taken = 1'b1;
      default:    r.taken = 1'b0;
    endcase
    r.redirect = r.taken ? r.target : r.link;
    r.mis = (r.taken != pt) || (r.taken && pt && (r.target != ptgt));
    return r;
  endfunction

  task automatic drive_op(input logic [3:0] op, input logic [XLEN-1:0] pc,
                          input logic [XLEN-1:0] imm, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic pt,
                          input logic [XLEN-1:0] ptgt, input logic [TW-1:0] tag);
    in_valid_i = 1'b1; op_i = op; pc_i = pc; imm_i = imm;
    rs1_val_i = a; rs2_val_i = b; pred_taken_i = pt; pred_target_i = ptgt; rob_tag_i = tag;
  endtask

  task automatic check_out(input string name, input res_t e, input logic [TW-1:0] tag);
    check({name, ".valid"},    out_valid_o,   1'b1);
    check({name, ".tag"},      rob_tag_o,     tag);
    check({name, ".taken"},    taken_o,       e.taken);
    check({name, ".target"},   target_o,      e.target);
    check({name, ".link"},     link_o,        e.link);
    check({name, ".redirect"}, redirect_pc_o, e.redirect);
    check({name, ".mispred"},  mispredict_o,  e.mis);
  endtask

  task automatic check_reset_state(input string name);
    check({name, ".out_valid"}, out_valid_o,   1'b0);
    check({name, ".in_ready"},  in_ready_o,    1'b1);
    check({name, ".taken"},     taken_o,       1'b0);
    check({name, ".mispred"},   mispredict_o,  1'b0);
    check({name, ".tag"},       rob_tag_o,     '0);
    check({name, ".target"},    target_o,      '0);
    check({name, ".link"},      link_o,        '0);
    check({name, ".redirect"},  redirect_pc_o, '0);
`ifdef BRU_STATS_EN
    check({name, ".stat_br"},   stat_branches_o, 32'd0);
    check({name, ".stat_mis"},  stat_mispred_o,  32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  vec_t          vecs[$];
  logic [TW-1:0] got[$];
  entry_t        q[$];
  res_t          r;
  int            exp_hs, exp_mis;
  logic          exp_ready, exp_valid;

  initial begin
    rst = 1'b0; in_valid_i = 1'b0; op_i = '0; pc_i = '0; imm_i = '0;
    rs1_val_i = '0; rs2_val_i = '0; pred_taken_i = 1'b0; pred_target_i = '0;
    rob_tag_i = '0; flush_i = 1'b0; out_ready_i = 1'b1;
    #1;
    check_reset_state("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // ---------------- directed vector table ----------------
    //          op     pc            imm           rs1           rs2          pt    ptgt                 taken target        link          redirect      mis
    vecs.push_back('{4'd1, 32'h100,      32'h20,       32'd5,        32'd5,        1'b0, 32'h0,      '{1'b0, 32'h120,      32'h104, 32'h104,  1'b0}});
    vecs.push_back('{4'd4, 32'h300,      32'h40,       32'hFFFFFFFF, 32'd1,        1'b0, 32'h0,      '{1'b1, 32'h340,      32'h304, 32'h340,  1'b1}});
    vecs.push_back('{4'd6, 32'h300,      32'h40,       32'hFFFFFFFF, 32'd1,        1'b0, 32'h0,      '{1'b0, 32'h340,      32'h304, 32'h304,  1'b0}});
    vecs.push_back('{4'd9, 32'h200,      32'h4,        32'h1001,     32'h0,        1'b1, 32'h1004,   '{1'b1, 32'h1004,     32'h204, 32'h1004, 1'b0}});
    vecs.push_back('{4'd9, 32'h200,      32'h4,        32'h1001,     32'h0,        1'b1, 32'h1008,   '{1'b1, 32'h1004,     32'h204, 32'h1004, 1'b1}});
    vecs.push_back('{4'd0, 32'h400,      32'hFFFFFFF0, 32'd7,        32'd7,        1'b1, 32'h3F0,    '{1'b1, 32'h3F0,      32'h404, 32'h3F0,  1'b0}});
    vecs.push_back('{4'd5, 32'h10,       32'h8,        32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 32'h0,      '{1'b1, 32'h18,       32'h14,  32'h18,   1'b1}});
    vecs.push_back('{4'd7, 32'h20,       32'h8,        32'd1,        32'hFFFFFFFF, 1'b1, 32'h28,     '{1'b0, 32'h28,       32'h24,  32'h24,   1'b1}});
    vecs.push_back('{4'd8, 32'hFFFFFFFC, 32'h8,        32'd0,        32'd0,        1'b1, 32'h4,      '{1'b1, 32'h4,        32'h0,   32'h4,    1'b0}});
    vecs.push_back('{4'd3, 32'h500,      32'h10,       32'd0,        32'd0,        1'b1, 32'h510,    '{1'b0, 32'h510,      32'h504, 32'h504,  1'b1}});
    vecs.push_back('{4'd1, 32'h600,      32'h100,      32'd1,        32'd2,        1'b1, 32'h604,    '{1'b1, 32'h700,      32'h604, 32'h700,  1'b1}});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_op(vecs[i].op, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].rs2,
               vecs[i].pt, vecs[i].ptgt, TW'(i));
      out_ready_i = 1'b1;
      #1 check("vec.in_ready", in_ready_o, 1'b1);
      @(negedge clk);
      in_valid_i = 1'b0;
      #1 check("vec.latency_n1", out_valid_o, 1'b0);
      @(negedge clk);
      #1 check_out($sformatf("vec%0d", i), vecs[i].exp, TW'(i));
    end

    // ---------------- backpressure: 3 ops, output stalled ----------------
    @(negedge clk);
    out_ready_i = 1'b0;
    drive_op(4'd0, 32'h1000, 32'h10, 32'd3, 32'd3, 1'b0, 32'h0, 4'd1);
    #1 check("bp.ready0", in_ready_o, 1'b1);
    @(negedge clk);
    drive_op(4'd1, 32'h2000, 32'h20, 32'd3, 32'd4, 1'b1, 32'h2020, 4'd2);
    #1 check("bp.ready1", in_ready_o, 1'b1);
    check("bp.valid1", out_valid_o, 1'b0);
    @(negedge clk);
    drive_op(4'd8, 32'h3000, 32'h30, 32'd0, 32'd0, 1'b0, 32'h0, 4'd3);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1 check("bp.ready_stall", in_ready_o, 1'b0);
      check_out("bp.hold", ref_result(4'd0, 32'h1000, 32'h10, 32'd3, 32'd3, 1'b0, 32'h0), 4'd1);
    end
    @(negedge clk);
    out_ready_i = 1'b1;
    #1 check("bp.ready_release", in_ready_o, 1'b1);
    got.delete();
    if (out_valid_o) got.push_back(rob_tag_o);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid_i = 1'b0;
      #1;
      if (out_valid_o) got.push_back(rob_tag_o);
    end
    check("bp.count", got.size(), 3);
    for (int k = 0; k < 3; k++)
      check("bp.order", (k < got.size()) ? got[k] : 'x, TW'(k + 1));

    // ---------------- flush with both stages valid ----------------
    @(negedge clk);
    out_ready_i = 1'b0;
    drive_op(4'd0, 32'h40, 32'h4, 32'd1, 32'd1, 1'b0, 32'h0, 4'd4);
    @(negedge clk);
    drive_op(4'd1, 32'h50, 32'h4, 32'd1, 32'd1, 1'b0, 32'h0, 4'd5);
    @(negedge clk);
    #1 check("fl.full_valid", out_valid_o, 1'b1);
    check("fl.full_ready", in_ready_o, 1'b0);
    flush_i = 1'b1;
    drive_op(4'd8, 32'h60, 32'h4, 32'd0, 32'd0, 1'b0, 32'h0, 4'd6);
    @(negedge clk);
    out_ready_i = 1'b1;
    drive_op(4'd8, 32'h70, 32'h4, 32'd0, 32'd0, 1'b0, 32'h0, 4'd7);
    #1 check("fl.valid_after", out_valid_o, 1'b0);
    check("fl.ready_during_flush", in_ready_o, 1'b1);
    @(negedge clk);
    flush_i = 1'b0;
    drive_op(4'd8, 32'h80, 32'h4, 32'd0, 32'd0, 1'b1, 32'h84, 4'd8);
    #1 check("fl.dropped_op", out_valid_o, 1'b0);
    @(negedge clk);
    in_valid_i = 1'b0;
    #1 check("fl.latency_n1", out_valid_o, 1'b0);
    @(negedge clk);
    #1 check_out("fl.next", ref_result(4'd8, 32'h80, 32'h4, 32'd0, 32'd0, 1'b1, 32'h84), 4'd8);
    @(negedge clk);
    #1 check("fl.no_extra", out_valid_o, 1'b0);

    // ---------------- asynchronous reset with ops in flight ----------------
    @(negedge clk);
    out_ready_i = 1'b0;
    drive_op(4'd9, 32'h90, 32'h8, 32'h123, 32'd0, 1'b0, 32'h0, 4'd9);
    @(negedge clk);
    drive_op(4'd4, 32'hA0, 32'h8, 32'd1, 32'd2, 1'b0, 32'h0, 4'd10);
    @(negedge clk);
    in_valid_i = 1'b0;
    #1 check("ar.before", out_valid_o, 1'b1);
    #2 rst = 1'b0;
    #1 check_reset_state("ar");
    @(negedge clk);
    rst = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk);
    #1 check("ar.stays_empty", out_valid_o, 1'b0);

    // ---------------- randomized traffic vs. queue model ----------------
    q.delete();
    exp_hs = 0; exp_mis = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid_i   = ($urandom_range(0, 9) < 7);
      op_i         = 4'($urandom_range(0, 15));
      pc_i         = $urandom & 32'hFFFF_FFFC;
      imm_i        = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 4095)) - 32'd2048 : $urandom;
      rs1_val_i    = $urandom;
      rs2_val_i    = ($urandom_range(0, 3) == 0) ? rs1_val_i : $urandom;
      pred_taken_i = $urandom_range(0, 1);
      r = ref_result(op_i, pc_i, imm_i, rs1_val_i, rs2_val_i, pred_taken_i, 32'h0);
      pred_target_i = ($urandom_range(0, 1) != 0) ? r.target : $urandom;
      rob_tag_i    = TW'($urandom_range(0, 15));
      out_ready_i  = ($urandom_range(0, 9) < 7);
      flush_i      = ($urandom_range(0, 99) < 3);
      #1;
      exp_ready = !((q.size() == 2) && !out_ready_i);
      exp_valid = (q.size() > 0) && (q[0].stamp + 2 <= c);
      check("rnd.in_ready", in_ready_o, exp_ready);
      check("rnd.out_valid", out_valid_o, exp_valid);
      if (exp_valid) check_out("rnd", q[0].res, q[0].tag);
      if (exp_valid && out_ready_i) begin
        exp_hs++;
        if (q[0].res.mis) exp_mis++;
        void'(q.pop_front());
      end
      if (flush_i) q.delete();
      else if (in_valid_i && exp_ready)
        q.push_back('{rob_tag_i,
                      ref_result(op_i, pc_i, imm_i, rs1_val_i, rs2_val_i, pred_taken_i, pred_target_i),
                      c});
    end
    @(negedge clk);
    in_valid_i = 1'b0; flush_i = 1'b0;
`ifdef BRU_STATS_EN
    #1 check("stat.branches", stat_branches_o, 32'(exp_hs));
    check("stat.mispred", stat_mispred_o, 32'(exp_mis));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-cycle BNE/jump branch unit.
- Resolves all RV32I conditional branches plus JAL and JALR.
- Checks both predicted direction and predicted target; produces a link value and a redirect PC.
- Two-stage valid/ready pipeline between the branch reservation station and the CDB/ROB, with backpressure and a pipeline flush.

Parameters:
XLEN, 32, operand/PC width (>=32)
ROB_TAG_W, 4, ROB tag width

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous active-low reset
in_valid_i  in  1  issue request
in_ready_o  out  1  unit can accept this cycle
op_i  in  4  0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU, 8 JAL, 9 JALR; others reserved
pc_i  in  XLEN  instruction PC
imm_i  in  XLEN  sign-extended offset
rs1_val_i  in  XLEN  source 1
rs2_val_i  in  XLEN  source 2
pred_taken_i  in  1  frontend predicted direction
pred_target_i  in  XLEN  frontend predicted target (meaningful when pred_taken_i=1)
rob_tag_i  in  ROB_TAG_W  ROB tag
flush_i  in  1  kill all in-flight ops
out_valid_o  out  1  result valid
out_ready_i  in  1  CDB accepts result
rob_tag_o  out  ROB_TAG_W  tag of result
taken_o  out  1  actual direction
target_o  out  XLEN  computed taken target
link_o  out  XLEN  pc+4 (JAL/JALR rd value)
redirect_pc_o  out  XLEN  correct next PC: taken ? target : pc+4
mispredict_o  out  1  frontend must redirect

Behaviour:
- Reset (rst=0, asynchronous): out_valid_o=0 and both internal stage valids=0. taken_o, mispredict_o, rob_tag_o, target_o, link_o and redirect_pc_o are all 0. in_ready_o=1 after reset.
- Stage E1: registers op, operands and pred fields on accept (in_valid_i && in_ready_o). Computes:
  - condition: eq, ne, signed lt/ge, unsigned lt/ge;
  - target = pc+imm for branches/JAL; (rs1+imm) with bit0 cleared for JALR;
  - link = pc+4.
  - All adds are modulo 2^XLEN.
- Stage E2: output register. Holds its contents stable while out_valid_o && !out_ready_i.
- Advance rules:
  - e2_free = !out_valid_o || out_ready_i;
  - e1_free = !e1_valid || e2_free;
  - in_ready_o = e1_free (combinational, no dependence on in_valid_i).
- Latency: accept at cycle N produces out_valid_o at N+2 without backpressure. Throughput is 1/cycle.
- taken:
  - JAL/JALR = 1; branches = condition result;
  - reserved op = 0, with target_o = pc+imm.
- mispredict_o = (taken != pred_taken) || (taken && pred_taken && target != pred_target).
- redirect_pc_o = taken ? target : link.
- flush_i (synchronous, priority over everything):
  - clears E1 and E2 valid next edge;
  - an op offered in the same cycle is dropped, and in_ready_o remains as computed;
  - out_valid_o=0 from the next cycle, even if out_ready_i=0.
- Simultaneous E2 drain and E1 refill in one cycle is allowed (full throughput under out_ready_i=1).
- Reset asserted mid-operation discards all in-flight ops immediately.

Optional Feature:
BRU_STATS_EN:
- Defined: adds outputs stat_branches_o[31:0] and stat_mispred_o[31:0].
  - Each increments by 1 on every out_valid_o && out_ready_i handshake (mispred counter only when mispredict_o=1).
  - Both saturate at 0xFFFFFFFF, reset to 0, and are not cleared by flush_i.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- BNE pc=0x100, imm=0x20, rs1=5, rs2=5, pred_taken=0, out_ready=1 -> 2 cycles later: out_valid=1, taken=0, mispredict=0, redirect_pc=0x104.
- BLT rs1=0xFFFFFFFF, rs2=1 (signed -1<1) and BLTU same operands -> BLT taken=1; BLTU taken=0. With pred_taken=0 each, mispredict=1 for BLT only.
- JALR pc=0x200, rs1=0x1001, imm=0x4, pred_taken=1, pred_target=0x1004 -> target=0x1004, link=0x204, mispredict=0. Repeat with pred_target=0x1008 -> mispredict=1, redirect_pc=0x1004.
- Back-to-back 3 ops with out_ready_i=0 for 4 cycles -> in_ready_o drops after 2 accepts; first result is held stable. Release -> results appear in order with tags preserved, none lost or duplicated.
- flush_i pulsed while both stages are valid and a new op is offered -> out_valid_o=0 next cycle, no flushed tag ever appears, next op after flush gets normal 2-cycle latency.
- Async reset asserted between clock edges with valid ops in flight -> out_valid_o=0 immediately, in_ready_o=1. With BRU_STATS_EN, counters=0.
